// File: rtl/adc_pkg.sv
// Shared types, frame constants and helpers for the MCP3004/3008 throttle ADC reader.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, CS_GAP} adc_state_t;

  localparam int FRAME_CLKS     = 17;
  localparam int FIRST_DATA_CLK = 8;
  localparam int ADC_BITS       = 10;
  localparam int ACCEL_MAX      = 15;
  localparam int HALF_EDGES     = 2 * FRAME_CLKS;

  // MOSI bit k of the frame: start, SGL, ch[2:0], then zeros.
  function automatic logic mosi_bit(input logic [5:0] idx, input logic [2:0] ch);
    case (idx)
      6'd0, 6'd1: mosi_bit = 1'b1;
      6'd2:       mosi_bit = ch[2];
      6'd3:       mosi_bit = ch[1];
      6'd4:       mosi_bit = ch[0];
      default:    mosi_bit = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] accel_of(input logic [ADC_BITS-1:0] code,
                                          input int offset, input int shift);
    logic signed [10:0] diff;
    logic        [10:0] scaled;
    diff   = $signed({1'b0, code}) - $signed(11'(offset));
    scaled = $unsigned(diff) >> shift;
    if (diff < 0)                     return 4'd0;
    else if (scaled > 11'(ACCEL_MAX)) return 4'(ACCEL_MAX);
    else                              return scaled[3:0];
  endfunction

endpackage

// File: rtl/adc_spi_if.sv
// SPI pin bundle between the reader (master) and the ADC (slave).
interface adc_spi_if;
    logic ad_clk;
    logic cs_n;
    logic din;
    logic dout;

    modport master (output ad_clk, output cs_n, output din, input dout);
    modport slave  (input ad_clk, input cs_n, input din, output dout);
endinterface

// File: rtl/adc_sclk_tick.sv
// Half-period timer: one-cycle tick every CLK_DIV clocks, restarted by clear.
module adc_sclk_tick #(
    parameter int CLK_DIV = 1350
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             cnt <= '0;
        else if (clear || tick) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/adc_spi_reader.sv
// Start-triggered SPI reader for an MCP3004/3008 ADC producing a sample and a 0-15 accel level.
// Optional macro ADC_AVG_EN: sample becomes a 4-deep moving average of raw codes.
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV      = 1350,
    parameter int ACCEL_OFFSET = 280,
    parameter int ACCEL_SHIFT  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          ch,
    output logic                busy,
    adc_spi_if.master           spi,
    output logic [ADC_BITS-1:0] sample,
    output logic                sample_valid,
    output logic [3:0]          accel
);
    adc_state_t          state, state_nxt;
    logic                tick, accept, cs_n_int;
    logic [5:0]          edge_cnt;
    logic                sclk_q, mosi_q, frame_done;
    logic [2:0]          ch_q;
    logic [ADC_BITS-1:0] shreg, sample_nxt;

    assign accept     = (state == IDLE) && start;
    assign spi.ad_clk = sclk_q;
    assign spi.din    = mosi_q;
    assign spi.cs_n   = cs_n_int;

    adc_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: default assignment first keeps every comb output driven on all paths, so no latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (tick && edge_cnt == 6'(HALF_EDGES - 1)) state_nxt = CS_HOLD;
            CS_HOLD: if (tick) state_nxt = CS_GAP;
            CS_GAP:  if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        cs_n_int = (state == IDLE) || (state == CS_GAP);
    end

    // Even edge_cnt values are SCLK rises, odd ones are falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt   <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ch_q       <= '0;
            shreg      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                edge_cnt <= '0;
                sclk_q   <= 1'b0;
                mosi_q   <= 1'b1;
                ch_q     <= ch;
            end else if (state == SHIFT && tick) begin
                edge_cnt <= edge_cnt + 6'd1;
                if (!edge_cnt[0]) begin
                    sclk_q <= 1'b1;
                    if (edge_cnt >= 6'(2 * (FIRST_DATA_CLK - 1)))
                        shreg <= {shreg[ADC_BITS-2:0], spi.dout};
                    if (edge_cnt == 6'(HALF_EDGES - 2))
                        frame_done <= 1'b1;
                end else begin
                    sclk_q <= 1'b0;
                    mosi_q <= mosi_bit(6'((edge_cnt + 6'd1) >> 1), ch_q);
                end
            end
        end
    end

`ifdef ADC_AVG_EN
    logic [ADC_BITS-1:0] hist [4];
    logic [11:0]         sum, sum_nxt;

    assign sum_nxt    = sum + 12'(shreg) - 12'(hist[3]);
    assign sample_nxt = sum_nxt[11:2];

    // NOTE: the history is reset explicitly because the first averages must see zeros, not X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            sum <= '0;
        end else if (frame_done) begin
            hist[0] <= shreg;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            sum <= sum_nxt;
        end
    end
`else
    assign sample_nxt = shreg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            accel        <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= frame_done;
            if (frame_done) begin
                sample <= sample_nxt;
                accel  <= accel_of(sample_nxt, ACCEL_OFFSET, ACCEL_SHIFT);
            end
        end
    end
endmodule
